fsk_tick_gen: RTL and testbench
===============================

# fsk_tick_gen

Parametrised multi-channel timebase for the FSK modem. It replaces ripple-clocked divider outputs with single-clock tick enables and registered square waves, all in the `clk` domain. It feeds the carrier synthesiser (f0/f1), the serial bit shifter and the sampler. Each channel has a runtime-programmable divisor with glitch-free update. Any channel can be cascaded off its lower neighbour's tick, and a global synchronous restart aligns all phases.

## Interface
- `NUM_CH`, 4: number of channels (1..16).
- `DIV_W`, 20: divisor/counter width.
- `RESET_DIV`, 40000: divisor loaded into every channel at reset.
- `CH_W`, `$clog2(NUM_CH)` (min 1): width of the channel select.

Ports:
- `clk`  in  1  system clock; all logic on the rising edge.
- `rst`  in  1  reset, synchronous and active-high.
- `ch_en`  in  NUM_CH  per-channel run enable.
- `cascade`  in  NUM_CH  per-channel mode.
  - Bit k=1 (k>0): channel k advances only on `tick[k-1]`.
  - Bit 0 is ignored.
- `cfg_wr`  in  1  one-cycle divisor write strobe.
- `cfg_ch`  in  CH_W  target channel of the write.
- `cfg_div`  in  DIV_W  new divisor D. Tick period is D+1 advances.
- `sync_restart`  in  1  realigns all channels.
- `tick`  out  NUM_CH  one-`clk`-cycle pulse per terminal count. Registered.
- `sq`  out  NUM_CH  square wave that toggles on each terminal count. Registered.

## Operation
- **Per-channel state:** `count` (DIV_W), `div_active`, `div_pending`, `tick_q`, `sq_q`.
- **Advance condition:** `ch_en[k]` and (`cascade[k]`=0, or k=0, or `tick[k-1]`=1).
- **On advance:**
  - If `count`==`div_active`: `count`←0, `tick`←1, `sq`←~`sq`, `div_active`←`div_pending`.
  - Otherwise: `count`←`count`+1, `tick`←0.
- **No advance:** `tick`←0. `count` and `sq` hold.
- **D=0:** tick on every advance; `sq` toggles on every advance.
- **Disabled channel** (`ch_en[k]`=0):
  - `count`←0, `sq`←0, `tick`←0.
  - `div_active`←`div_pending` every cycle.
- **Re-enable:** counting starts from 0. The first tick occurs after D+1 advances.
- **Config write:**
  - `cfg_wr` with `cfg_ch`<NUM_CH updates `div_pending[cfg_ch]`.
  - `cfg_ch`≥NUM_CH is ignored.
  - If the write coincides with that channel's wrap, the written value goes straight into `div_active` (bypass).
  - Writes never change the current period mid-count.
- **`sync_restart`:** on all channels, `count`←0, `sq`←0, `tick`←0, `div_active`←`div_pending` (pending includes a coincident `cfg_wr`).
- **Priority:** `rst` > `sync_restart` > disable > advance.
- **Reset values:** `count`=0, `tick`=0, `sq`=0, `div_active`=`div_pending`=`RESET_DIV`.
- **Reset mid-count:** everything returns to the reset values. Pending writes are lost.
- **Arithmetic:** unsigned. `count` never exceeds `div_active`, so there is no wrap beyond D.

## Timing
- **Standalone channel:** with constant `ch_en` and constant D, `tick` has period D+1 cycles and `sq` has period 2(D+1) cycles at 50% duty.
- **First tick after reset:** let e0 be the first edge sampling `rst`=0. `count` is 1 after e0 and `tick` rises after edge eD. So `tick` is high during cycle D+1, and `sq` rises at the same edge.
- **Cascaded channel k:**
  - Period is (D[k-1]+1)(D[k]+1) cycles.
  - Its `tick` rises one `clk` after the qualifying `tick[k-1]` edge.
  - Latency accumulates by 1 cycle per cascade stage.
- **After `sync_restart`:** the same timing as after reset, with e0 being the edge after the strobe.
- **Divisor writes:** latency is zero for disabled channels. For running channels, the new value applies from the next wrap.
- **Single-cycle guarantee:** `tick` is never high for two consecutive cycles unless D=0 and the channel advances every cycle.

## Structure
- **Package `fsk_clk_pkg`:** default `DIV_W`, `RESET_DIV`, carrier/bit/sample default divisors (40000, 4, 24, 399), and the `div_t` typedef (`logic [DIV_W-1:0]`).
- **Sub-module `fsk_tick_chan`:** one channel (counter, shadow/active divisor, tick/sq registers) with inputs `adv`, `en`, `restart`, `wr`, `wdiv`.
- **Top:** instantiates `NUM_CH` channels via generate and wires the cascade chain. No other logic.

## Test plan
- **Reset and default divisor:** NUM_CH=4, RESET_DIV=3, all enabled, cascade=0 → every `tick` is high in cycles 4, 8, 12…; `sq` rises at 4 and falls at 8.
- **Cascade:** D0=1, D1=2, `cascade[1]`=1 → `tick[1]` period is 6 cycles, each pulse 1 cycle after a `tick[0]` pulse; `sq[1]` period is 12 cycles.
- **Glitch-free write:** D=9 running; write D=2 at count=4 → the current period is still 10 cycles, then periods are 3. A second case writes exactly in the wrap cycle → the following period is 3 (bypass).
- **Disable/re-enable:** drop `ch_en` mid-count → `sq`=0 and `tick`=0 next cycle. Re-enable with D=5 → the first tick is 6 cycles later.
- **`sync_restart` with coincident `cfg_wr`** (ch2, D=7) → all channels restart phase-aligned, and ch2's first tick comes 8 cycles later.
- **Edge cases:** D=0 gives `tick` stuck high and `sq` toggling every cycle. `cfg_ch`=5 with NUM_CH=4 leaves all divisors unchanged. `rst` asserted together with `sync_restart` leaves reset values.

Source files
------------

// File: rtl/fsk_clk_pkg.sv
// rtl/fsk_clk_pkg.sv - shared widths, default divisors and types for the FSK timebase
package fsk_clk_pkg;

    localparam int DIV_W_DEFAULT     = 20;
    localparam int RESET_DIV_DEFAULT = 40000;

    localparam int DIV_CARRIER_F0 = 40000;
    localparam int DIV_CARRIER_F1 = 4;
    localparam int DIV_BIT        = 24;
    localparam int DIV_SAMPLE     = 399;

    typedef logic [DIV_W_DEFAULT-1:0] div_t;

endpackage

// File: rtl/fsk_tick_chan.sv
// rtl/fsk_tick_chan.sv - one divider channel: counter, shadow/active divisor, tick and square registers
module fsk_tick_chan
    import fsk_clk_pkg::*;
#(
    parameter int DIV_W     = DIV_W_DEFAULT,
    parameter int RESET_DIV = RESET_DIV_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             adv,
    input  logic             en,
    input  logic             restart,
    input  logic             wr,
    input  logic [DIV_W-1:0] wdiv,
    output logic             tick,
    output logic             sq
);

    logic [DIV_W-1:0] r_count;
    logic [DIV_W-1:0] r_div_active;
    logic [DIV_W-1:0] r_div_pending;
    logic             r_tick;
    logic             r_sq;
    logic [DIV_W-1:0] w_pending_next;

    // A write in the same cycle as a reload is taken directly into the active divisor.
    assign w_pending_next = wr ? wdiv : r_div_pending;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count       <= '0;
            r_tick        <= 1'b0;
            r_sq          <= 1'b0;
            r_div_active  <= DIV_W'(RESET_DIV);
            r_div_pending <= DIV_W'(RESET_DIV);
        end else begin
            r_div_pending <= w_pending_next;
            if (restart || !en) begin
                r_count      <= '0;
                r_tick       <= 1'b0;
                r_sq         <= 1'b0;
                r_div_active <= w_pending_next;
            end else if (adv) begin
                if (r_count == r_div_active) begin
                    r_count      <= '0;
                    r_tick       <= 1'b1;
                    r_sq         <= ~r_sq;
                    r_div_active <= w_pending_next;
                end else begin
                    r_count <= r_count + DIV_W'(1);
                    r_tick  <= 1'b0;
                end
            end else begin
                r_tick <= 1'b0;
            end
        end
    end

    assign tick = r_tick;
    assign sq   = r_sq;

endmodule

// File: rtl/fsk_tick_gen.sv
// rtl/fsk_tick_gen.sv - multi-channel tick/square timebase with optional cascade chain
module fsk_tick_gen
    import fsk_clk_pkg::*;
#(
    parameter int NUM_CH    = 4,
    parameter int DIV_W     = DIV_W_DEFAULT,
    parameter int RESET_DIV = RESET_DIV_DEFAULT,
    parameter int CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_CH-1:0] ch_en,
    input  logic [NUM_CH-1:0] cascade,
    input  logic              cfg_wr,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [DIV_W-1:0]  cfg_div,
    input  logic              sync_restart,
    output logic [NUM_CH-1:0] tick,
    output logic [NUM_CH-1:0] sq
);

    logic [NUM_CH-1:0] w_prev_tick;
    logic [NUM_CH-1:0] w_adv;
    logic [NUM_CH-1:0] w_wr;

    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
        // Channel 0 has no lower neighbour, so it always sees a qualifying tick.
        if (k == 0) begin : g_head
            assign w_prev_tick[k] = 1'b1;
        end else begin : g_link
            assign w_prev_tick[k] = tick[k-1];
        end

        assign w_adv[k] = ch_en[k] & (~cascade[k] | w_prev_tick[k]);
        assign w_wr[k]  = cfg_wr & (cfg_ch == CH_W'(k));

        fsk_tick_chan #(
            .DIV_W     (DIV_W),
            .RESET_DIV (RESET_DIV)
        ) u_chan (
            .clk     (clk),
            .rst     (rst),
            .adv     (w_adv[k]),
            .en      (ch_en[k]),
            .restart (sync_restart),
            .wr      (w_wr[k]),
            .wdiv    (cfg_div),
            .tick    (tick[k]),
            .sq      (sq[k])
        );
    end

endmodule

// File: tb/tb_fsk_tick_gen.sv
// tb/tb_fsk_tick_gen.sv - directed self-checking bench for fsk_tick_gen
module tb_fsk_tick_gen;

    localparam int NUM_CH = 4;
    localparam int DIV_W  = 20;
    localparam int CH_W   = 3;

    logic              clk = 1'b0;
    logic              rst;
    logic [NUM_CH-1:0] ch_en;
    logic [NUM_CH-1:0] cascade;
    logic              cfg_wr;
    logic [CH_W-1:0]   cfg_ch;
    logic [DIV_W-1:0]  cfg_div;
    logic              sync_restart;
    logic [NUM_CH-1:0] tick;
    logic [NUM_CH-1:0] sq;

    int n_checks = 0;
    int n_fail   = 0;

    fsk_tick_gen #(
        .NUM_CH    (NUM_CH),
        .DIV_W     (DIV_W),
        .RESET_DIV (3),
        .CH_W      (CH_W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .ch_en        (ch_en),
        .cascade      (cascade),
        .cfg_wr       (cfg_wr),
        .cfg_ch       (cfg_ch),
        .cfg_div      (cfg_div),
        .sync_restart (sync_restart),
        .tick         (tick),
        .sq           (sq)
    );

    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; ch_en = '0; cascade = '0; cfg_wr = 1'b0;
        cfg_ch = '0; cfg_div = '0; sync_restart = 1'b0;
        step(2);
        rst = 1'b0;
    endtask

    task automatic write_div(input int ch, input int d);
        cfg_wr = 1'b1; cfg_ch = CH_W'(ch); cfg_div = DIV_W'(d);
        step(1);
        cfg_wr = 1'b0;
    endtask

    task automatic test_reset();
        logic [NUM_CH-1:0] exp_t, exp_s;
        rst = 1'b1; ch_en = '1; cascade = '0; cfg_wr = 1'b0;
        cfg_ch = '0; cfg_div = '0; sync_restart = 1'b0;
        step(2);
        n_checks++;
        if (tick !== '0 || sq !== '0) begin
            n_fail++;
            $display("FAIL reset_state: tick=%b sq=%b required 0000/0000", tick, sq);
        end
        rst = 1'b0;
        for (int i = 1; i <= 13; i++) begin
            step(1);
            exp_t = (i % 4 == 0) ? '1 : '0;
            exp_s = (((i / 4) % 2) == 1) ? '1 : '0;
            n_checks++;
            if (tick !== exp_t || sq !== exp_s) begin
                n_fail++;
                $display("FAIL default_div edge %0d: tick=%b sq=%b required %b/%b", i, tick, sq, exp_t, exp_s);
            end
        end
    endtask

    task automatic test_cascade();
        logic [1:0] exp_t;
        logic       exp_s1;
        do_reset();
        write_div(0, 1);
        write_div(1, 2);
        cascade = 4'b0010;
        ch_en   = 4'b0011;
        for (int i = 1; i <= 30; i++) begin
            step(1);
            exp_t[0] = (i % 2 == 0);
            exp_t[1] = (i >= 7) && ((i - 7) % 6 == 0);
            exp_s1   = (i >= 7) && ((((i - 7) / 6) % 2) == 0);
            n_checks++;
            if (tick[1:0] !== exp_t || sq[1] !== exp_s1) begin
                n_fail++;
                $display("FAIL cascade edge %0d: tick=%b sq1=%b required %b/%b", i, tick[1:0], sq[1], exp_t, exp_s1);
            end
        end
    endtask

    task automatic test_glitch_free_write();
        logic exp_t;
        do_reset();
        write_div(0, 9);
        ch_en = 4'b0001;
        cfg_ch = '0; cfg_div = DIV_W'(2);
        for (int i = 1; i <= 19; i++) begin
            cfg_wr = (i == 5);
            step(1);
            exp_t = (i == 10) || (i == 13) || (i == 16) || (i == 19);
            n_checks++;
            if (tick[0] !== exp_t) begin
                n_fail++;
                $display("FAIL write_mid_count edge %0d: tick0=%b required %b", i, tick[0], exp_t);
            end
        end
        cfg_wr = 1'b0;
        do_reset();
        write_div(0, 9);
        ch_en = 4'b0001;
        cfg_ch = '0; cfg_div = DIV_W'(2);
        for (int i = 1; i <= 16; i++) begin
            cfg_wr = (i == 10);
            step(1);
            exp_t = (i == 10) || (i == 13) || (i == 16);
            n_checks++;
            if (tick[0] !== exp_t) begin
                n_fail++;
                $display("FAIL write_bypass edge %0d: tick0=%b required %b", i, tick[0], exp_t);
            end
        end
        cfg_wr = 1'b0;
    endtask

    task automatic test_disable_reenable();
        logic exp_t, exp_s;
        do_reset();
        ch_en = '1;
        step(6);
        ch_en = '0;
        write_div(0, 5);
        n_checks++;
        if (tick !== '0 || sq !== '0) begin
            n_fail++;
            $display("FAIL disable: tick=%b sq=%b required 0000/0000", tick, sq);
        end
        ch_en = 4'b0001;
        for (int i = 1; i <= 12; i++) begin
            step(1);
            exp_t = (i == 6) || (i == 12);
            exp_s = (i >= 6) && (i < 12);
            n_checks++;
            if (tick[0] !== exp_t || sq[0] !== exp_s) begin
                n_fail++;
                $display("FAIL reenable edge %0d: tick0=%b sq0=%b required %b/%b", i, tick[0], sq[0], exp_t, exp_s);
            end
        end
    endtask

    task automatic test_sync_restart();
        logic [NUM_CH-1:0] exp_t;
        do_reset();
        write_div(1, 1);
        ch_en = '1;
        step(5);
        sync_restart = 1'b1;
        cfg_wr = 1'b1; cfg_ch = CH_W'(2); cfg_div = DIV_W'(7);
        step(1);
        sync_restart = 1'b0;
        cfg_wr = 1'b0;
        n_checks++;
        if (tick !== '0 || sq !== '0) begin
            n_fail++;
            $display("FAIL sync_restart_clear: tick=%b sq=%b required 0000/0000", tick, sq);
        end
        for (int i = 1; i <= 8; i++) begin
            step(1);
            exp_t = {(i % 4 == 0), (i == 8), (i % 2 == 0), (i % 4 == 0)};
            n_checks++;
            if (tick !== exp_t) begin
                n_fail++;
                $display("FAIL sync_restart edge %0d: tick=%b required %b", i, tick, exp_t);
            end
        end
    endtask

    task automatic test_edge_cases();
        logic [NUM_CH-1:0] exp_t;
        do_reset();
        write_div(0, 0);
        ch_en = 4'b0001;
        for (int i = 1; i <= 6; i++) begin
            step(1);
            n_checks++;
            if (tick[0] !== 1'b1 || sq[0] !== logic'(i % 2)) begin
                n_fail++;
                $display("FAIL d_zero edge %0d: tick0=%b sq0=%b required 1/%0d", i, tick[0], sq[0], i % 2);
            end
        end
        do_reset();
        write_div(5, 0);
        ch_en = '1;
        for (int i = 1; i <= 4; i++) begin
            step(1);
            exp_t = (i == 4) ? '1 : '0;
            n_checks++;
            if (tick !== exp_t) begin
                n_fail++;
                $display("FAIL cfg_ch_out_of_range edge %0d: tick=%b required %b", i, tick, exp_t);
            end
        end
        step(1);
        rst = 1'b1; sync_restart = 1'b1;
        cfg_wr = 1'b1; cfg_ch = '0; cfg_div = DIV_W'(1);
        step(1);
        rst = 1'b0; sync_restart = 1'b0; cfg_wr = 1'b0; ch_en = '0;
        n_checks++;
        if (tick !== '0 || sq !== '0) begin
            n_fail++;
            $display("FAIL rst_with_restart: tick=%b sq=%b required 0000/0000", tick, sq);
        end
        step(1);
        ch_en = 4'b0001;
        for (int i = 1; i <= 4; i++) begin
            step(1);
            n_checks++;
            if (tick[0] !== (i == 4)) begin
                n_fail++;
                $display("FAIL rst_drops_write edge %0d: tick0=%b required %b", i, tick[0], (i == 4));
            end
        end
    endtask

    initial begin
        test_reset();
        test_cascade();
        test_glitch_free_write();
        test_disable_reenable();
        test_sync_restart();
        test_edge_cases();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
